spmmio_dbgmaster: RTL and testbench

- Wishbone initiator driving the spmmio slave bus from a byte-stream command channel, e.g. a host debug UART, for register peek/poke without the service CPU.
- Parses fixed-format read/write commands from an rx byte stream and issues single 32-bit classic Wishbone cycles.
- Returns status and read data on a tx byte stream; a bounded ack timeout prevents hangs on unmapped or stalled slaves.

---
 rtl/spmmio_dbgmaster.sv | 168 ++++++++++++++++
 tb/tb_spmmio_dbgmaster.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmmio_dbgmaster.sv
// spmmio_dbgmaster: debug bus master for the spmmio Wishbone bus.
// Takes fixed-format peek/poke commands from a byte stream (e.g. a host UART),
// runs one 32-bit classic Wishbone cycle per command, and returns a status
// byte, plus read data for reads, on a response byte stream.
// Stalled or unmapped slaves are abandoned after a bounded number of
// strobe cycles, so the master cannot hang.
module spmmio_dbgmaster #(
  parameter int timeout = 255  // max non-ack strobe cycles, 1..65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:7]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [0:7]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [0:23] adr_o,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [0:3]  sel_o,
  output logic        we_o,
  output logic [0:31] dat_o,
  input  logic        ack_i,
  input  logic [0:31] dat_i
);

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  localparam logic [3:0]  op_nop   = 4'h0;
  localparam logic [3:0]  op_write = 4'h1;
  localparam logic [3:0]  op_read  = 4'h2;
  localparam logic [7:0]  resp_ok  = 8'h4B;
  localparam logic [7:0]  resp_tmo = 8'h54;
  localparam logic [7:0]  resp_bad = 8'h3F;
  // Counter value at which the current non-ack cycle is the last one allowed.
  localparam logic [15:0] last_wait = 16'(timeout - 1);

  state_t      state_reg;
  logic [15:0] wait_cnt_reg;   // strobe cycles seen without ack
  logic [2:0]  byte_cnt_reg;   // bytes taken in ADDR/WDATA, bytes still owed in RESP
  logic [0:31] rd_data_reg;    // read data, shifted out MSB byte first

  // Command parser, bus cycle sequencer and response sender in one FSM;
  // every output is a register so nothing reaches the pins combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= '0;
      byte_cnt_reg <= '0;
      rd_data_reg  <= '0;
      rx_ready     <= 1'b1;
      tx_valid     <= 1'b0;
      tx_data      <= '0;
      adr_o        <= '0;
      cyc_o        <= 1'b0;
      stb_o        <= 1'b0;
      sel_o        <= '0;
      we_o         <= 1'b0;
      dat_o        <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rx_valid) begin
            byte_cnt_reg <= '0;
            case (rx_data[0:3])
              op_nop: ;  // sync byte: swallow and keep waiting
              op_write, op_read: begin
                we_o      <= (rx_data[0:3] == op_write);
                sel_o     <= rx_data[4:7];
                state_reg <= ADDR;
              end
              default: begin
                // Unknown opcode: report it and do not attempt any framing.
                rx_ready  <= 1'b0;
                tx_data   <= resp_bad;
                tx_valid  <= 1'b1;
                state_reg <= RESP;
              end
            endcase
          end
        end

        ADDR: begin
          if (rx_valid) begin
            byte_cnt_reg <= byte_cnt_reg + 3'd1;
            if (byte_cnt_reg == 3'd2) begin
              // Last address byte: the word-offset bits never leave the master.
              adr_o        <= {adr_o[8:23], rx_data[0:5], 2'b00};
              byte_cnt_reg <= '0;
              if (we_o) begin
                state_reg <= WDATA;
              end else begin
                rx_ready     <= 1'b0;
                cyc_o        <= 1'b1;
                stb_o        <= 1'b1;
                wait_cnt_reg <= '0;
                state_reg    <= BUS;
              end
            end else begin
              adr_o <= {adr_o[8:23], rx_data};
            end
          end
        end

        WDATA: begin
          if (rx_valid) begin
            dat_o        <= {dat_o[8:31], rx_data};
            byte_cnt_reg <= byte_cnt_reg + 3'd1;
            if (byte_cnt_reg == 3'd3) begin
              rx_ready     <= 1'b0;
              cyc_o        <= 1'b1;
              stb_o        <= 1'b1;
              wait_cnt_reg <= '0;
              state_reg    <= BUS;
            end
          end
        end

        BUS: begin
          // Ack wins over timeout when both land on the same edge.
          if (ack_i) begin
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            rd_data_reg  <= dat_i;
            tx_data      <= resp_ok;
            tx_valid     <= 1'b1;
            byte_cnt_reg <= we_o ? 3'd0 : 3'd4;
            state_reg    <= RESP;
          end else if (wait_cnt_reg == last_wait) begin
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            tx_data      <= resp_tmo;
            tx_valid     <= 1'b1;
            byte_cnt_reg <= '0;
            state_reg    <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
          end
        end

        RESP: begin
          // tx_data only moves on an accepted handshake, so it holds under backpressure.
          if (tx_ready) begin
            if (byte_cnt_reg == 3'd0) begin
              tx_valid  <= 1'b0;
              rx_ready  <= 1'b1;
              state_reg <= IDLE;
            end else begin
              tx_data      <= rd_data_reg[0:7];
              rd_data_reg  <= {rd_data_reg[8:31], 8'h00};
              byte_cnt_reg <= byte_cnt_reg - 3'd1;
            end
          end
        end

        default: begin
          state_reg <= IDLE;
          rx_ready  <= 1'b1;
          tx_valid  <= 1'b0;
          cyc_o     <= 1'b0;
          stb_o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spmmio_dbgmaster.sv
// tb_spmmio_dbgmaster: directed bench for the spmmio debug bus master.
// A small Wishbone slave model supplies ack after a programmable wait;
// monitors capture bus cycles and the response stream for checking.
module tb_spmmio_dbgmaster;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [0:7]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [0:7]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [0:23] adr_o;
  logic        cyc_o;
  logic        stb_o;
  logic [0:3]  sel_o;
  logic        we_o;
  logic [0:31] dat_o;
  logic        ack_i;
  logic [0:31] dat_i = '0;

  spmmio_dbgmaster #(.timeout(4)) dut (
    .clk(clk), .reset(reset),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .adr_o(adr_o), .cyc_o(cyc_o), .stb_o(stb_o), .sel_o(sel_o),
    .we_o(we_o), .dat_o(dat_o), .ack_i(ack_i), .dat_i(dat_i)
  );

  always #5 clk = ~clk;

  // Slave model: ack once stb_o has been high for ack_wait cycles.
  logic ack_en = 1'b1;
  int   ack_wait = 0;
  int   wait_cnt = 0;
  always @(posedge clk) wait_cnt <= stb_o ? wait_cnt + 1 : 0;
  always_comb ack_i = ack_en && stb_o && (wait_cnt >= ack_wait);

  // Response sink with optional 1-in-3 backpressure.
  logic bp_mode = 1'b0;
  int   tick = 0;
  initial tx_ready = 1'b1;
  always @(negedge clk) begin
    tick = tick + 1;
    tx_ready = bp_mode ? ((tick % 3) == 0) : 1'b1;
  end

  // Response collector plus hold-under-backpressure checker.
  logic [7:0] tx_q[$];
  logic       hold_pending = 1'b0;
  logic [7:0] held = '0;
  int         hold_err = 0;
  always @(posedge clk) begin
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
    if (hold_pending && tx_valid && tx_data != held) hold_err <= hold_err + 1;
    hold_pending <= tx_valid && !tx_ready;
    held <= tx_data;
  end

  // Bus monitor: strobe length, captured cycle, stability and rx_ready misuse.
  int          stb_total = 0;
  logic        stb_prev = 1'b0;
  logic [0:23] cap_adr = '0;
  logic [0:3]  cap_sel = '0;
  logic        cap_we = 1'b0;
  logic [0:31] cap_dat = '0;
  int          instab = 0;
  int          rx_bad = 0;
  int          cyc_bad = 0;
  always @(negedge clk) begin
    if (stb_o) begin
      stb_total <= stb_total + 1;
      cap_adr <= adr_o; cap_sel <= sel_o; cap_we <= we_o; cap_dat <= dat_o;
      if (stb_prev && (adr_o != cap_adr || sel_o != cap_sel || we_o != cap_we || dat_o != cap_dat))
        instab <= instab + 1;
    end
    if (rx_ready && (stb_o || tx_valid)) rx_bad <= rx_bad + 1;
    if (cyc_o != stb_o) cyc_bad <= cyc_bad + 1;
    stb_prev <= stb_o;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [7:0] cmd_buf [8];

  // Sends cmd_buf[0..n-1]; must be called just after a negedge.
  task automatic send_cmd(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      rx_data = cmd_buf[i];
      rx_valid = 1'b1;
      while (!rx_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) check("rx_accept_timeout", 0, 1);
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  // Waits until n response bytes past base arrived and the master is idle.
  task automatic wait_done(input int base, input int n);
    int guard = 0;
    while (!(tx_q.size() >= base + n && rx_ready && !tx_valid && !stb_o) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("resp_wait_timeout", 0, 1);
    repeat (5) @(negedge clk);
  endtask

  task automatic expect_tx(input string tag, input int base, input int n, input logic [39:0] exp);
    check({tag, "_count"}, tx_q.size() - base, n);
    for (int i = 0; i < n; i++)
      if (base + i < tx_q.size())
        check($sformatf("%s_byte%0d", tag, i), tx_q[base + i], exp[39 - 8*i -: 8]);
  endtask

  task automatic set_cmd4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    cmd_buf[0] = a; cmd_buf[1] = b; cmd_buf[2] = c; cmd_buf[3] = d;
  endtask

  task automatic set_wdata(input logic [31:0] w);
    cmd_buf[4] = w[31:24]; cmd_buf[5] = w[23:16]; cmd_buf[6] = w[15:8]; cmd_buf[7] = w[7:0];
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int base;
    int s0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    // Reset state
    check("rst_rx_ready", rx_ready, 1);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_cyc_stb", {cyc_o, stb_o, we_o}, 0);
    check("rst_adr", adr_o, 0);
    check("rst_sel", sel_o, 0);
    check("rst_dat", dat_o, 0);
    reset = 1'b0;
    @(negedge clk);

    // Write, ack tied to strobe
    ack_en = 1; ack_wait = 0;
    base = tx_q.size(); s0 = stb_total;
    set_cmd4(8'h11, 8'h00, 8'h00, 8'h04); set_wdata(32'hDEADBEEF);
    send_cmd(8); wait_done(base, 1);
    check("wr_stb_len", stb_total - s0, 1);
    check("wr_adr", cap_adr, 24'h000004);
    check("wr_we", cap_we, 1);
    check("wr_sel", cap_sel, 4'h1);
    check("wr_dat", cap_dat, 32'hDEADBEEF);
    expect_tx("wr_tx", base, 1, 40'h4B_00000000);
    $display("write  adr=%h dat=%h stb=%0d", cap_adr, cap_dat, stb_total - s0);

    // Read, 3 wait states
    ack_wait = 3; dat_i = 32'h12345678;
    base = tx_q.size(); s0 = stb_total;
    set_cmd4(8'h2F, 8'h01, 8'h00, 8'h08);
    send_cmd(4); wait_done(base, 5);
    check("rd_stb_len", stb_total - s0, 4);
    check("rd_we", cap_we, 0);
    check("rd_sel", cap_sel, 4'hF);
    check("rd_adr", cap_adr, 24'h010008);
    expect_tx("rd_tx", base, 5, 40'h4B_12345678);
    $display("read   adr=%h stb=%0d bytes=%0d", cap_adr, stb_total - s0, tx_q.size() - base);

    // Timeout then a normal write
    ack_en = 0;
    base = tx_q.size(); s0 = stb_total;
    set_cmd4(8'h2F, 8'h00, 8'h00, 8'h10);
    send_cmd(4); wait_done(base, 1);
    check("tmo_stb_len", stb_total - s0, 4);
    expect_tx("tmo_tx", base, 1, 40'h54_00000000);
    $display("timeout stb=%0d bytes=%0d", stb_total - s0, tx_q.size() - base);
    ack_en = 1; ack_wait = 0;
    base = tx_q.size(); s0 = stb_total;
    set_cmd4(8'h13, 8'h00, 8'h00, 8'h20); set_wdata(32'h01020304);
    send_cmd(8); wait_done(base, 1);
    check("post_tmo_stb_len", stb_total - s0, 1);
    check("post_tmo_dat", cap_dat, 32'h01020304);
    check("post_tmo_sel", cap_sel, 4'h3);
    expect_tx("post_tmo_tx", base, 1, 40'h4B_00000000);
    $display("write  adr=%h dat=%h stb=%0d", cap_adr, cap_dat, stb_total - s0);

    // Framing: NOP is silent, bad opcode answers 3F, low address bits forced to 0
    base = tx_q.size(); s0 = stb_total;
    cmd_buf[0] = 8'h00; send_cmd(1); wait_done(base, 0);
    check("nop_no_tx", tx_q.size() - base, 0);
    check("nop_no_bus", stb_total - s0, 0);
    cmd_buf[0] = 8'h7F; send_cmd(1); wait_done(base, 1);
    expect_tx("bad_tx", base, 1, 40'h3F_00000000);
    check("bad_no_bus", stb_total - s0, 0);
    base = tx_q.size();
    set_cmd4(8'h1F, 8'hAB, 8'hCD, 8'h07); set_wdata(32'hCAFEF00D);
    send_cmd(8); wait_done(base, 1);
    check("frm_adr", cap_adr, 24'hABCD04);
    check("frm_dat", cap_dat, 32'hCAFEF00D);
    expect_tx("frm_tx", base, 1, 40'h4B_00000000);
    $display("framing adr=%h bytes=%0d", cap_adr, tx_q.size() - base);

    // Backpressure on a read
    dat_i = 32'hA1B2C3D4; bp_mode = 1;
    base = tx_q.size();
    set_cmd4(8'h28, 8'h00, 8'h00, 8'h0C);
    send_cmd(4); wait_done(base, 5);
    bp_mode = 0;
    expect_tx("bp_tx", base, 5, 40'h4B_A1B2C3D4);
    check("bp_sel", cap_sel, 4'h8);
    check("bp_hold", hold_err, 0);
    $display("backpressure bytes=%0d hold_err=%0d", tx_q.size() - base, hold_err);

    // Reset in the middle of a bus cycle
    ack_en = 0;
    base = tx_q.size();
    set_cmd4(8'h2F, 8'h00, 8'h00, 8'h30);
    send_cmd(4);
    begin
      int guard = 0;
      while (!stb_o && guard < 20) begin @(negedge clk); guard++; end
      check("rstmid_stb_seen", stb_o, 1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstmid_cyc_stb", {cyc_o, stb_o}, 0);
    check("rstmid_tx_valid", tx_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("rstmid_no_tx", tx_q.size() - base, 0);
    check("rstmid_rx_ready", rx_ready, 1);
    ack_en = 1; ack_wait = 1;
    base = tx_q.size(); s0 = stb_total;
    set_cmd4(8'h1C, 8'h00, 8'h00, 8'h40); set_wdata(32'h55AA00FF);
    send_cmd(8); wait_done(base, 1);
    check("rstmid_next_stb", stb_total - s0, 2);
    check("rstmid_next_adr", cap_adr, 24'h000040);
    check("rstmid_next_dat", cap_dat, 32'h55AA00FF);
    expect_tx("rstmid_next_tx", base, 1, 40'h4B_00000000);
    $display("reset-mid then write adr=%h stb=%0d", cap_adr, stb_total - s0);

    // Global invariants
    check("rx_ready_busy", rx_bad, 0);
    check("bus_stable", instab, 0);
    check("cyc_eq_stb", cyc_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
